// File: rtl/logic_gate_pkg.sv
// Shared op-code definitions for the logic_gate_pipe reduction datapath.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_OR   = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    // Codes above OP_XNOR carry no operation and flag an error.
    function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
        return (op > OP_XNOR);
    endfunction

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN operands under a selectable op.
module logic_reduce
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]         op,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] xor_r;

    always_comb begin
        or_r  = '0;
        and_r = '1;
        xor_r = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            or_r  = or_r  | in_data[k*WIDTH +: WIDTH];
            and_r = and_r & in_data[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Inverted ops invert the complete reduction; reserved codes force zero.
    always_comb begin
        result = '0;
        err    = is_reserved_op(op);
        case (op)
            OP_OR:   result = or_r;
            OP_AND:  result = and_r;
            OP_XOR:  result = xor_r;
            OP_NOR:  result = ~or_r;
            OP_NAND: result = ~and_r;
            OP_XNOR: result = ~xor_r;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered NUM_IN-operand bitwise combiner with valid/ready handshake and beat counter.
// Optional OR-accumulator enabled by defining LOGIC_GATE_PIPE_ACCUM_EN.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]         in_op,
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
    input  logic                    acc_en,
    input  logic                    acc_clr,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic [CNT_W-1:0]        beat_cnt
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_err_q,   out_err_d;
    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;

    logic [WIDTH-1:0] red_result;
    logic             red_err;
    logic             accept;
    logic             pop;

    logic_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .in_data (in_data),
        .op      (in_op),
        .result  (red_result),
        .err     (red_err)
    );

    // Ready whenever the output slot is empty or is being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

`ifdef LOGIC_GATE_PIPE_ACCUM_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_merged;

    // A clear in the same cycle as a beat takes effect before the merge.
    assign acc_base   = acc_clr ? '0 : acc_q;
    assign acc_merged = red_result | acc_base;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end
        if (accept && !red_err && acc_en) begin
            acc_d = acc_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_err_d   = red_err;
            out_data_d  = red_result;
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
            if (!red_err && acc_en) begin
                out_data_d = acc_merged;
            end
`endif
            beat_cnt_d  = beat_cnt_q + CNT_W'(1);
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=8, NUM_IN=3, CNT_W=4).
module tb_logic_gate_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [2:0]              in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic [CNT_W-1:0]        beat_cnt;
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
    logic                    acc_en;
    logic                    acc_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    logic_gate_pipe #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #6;
        rst_n = 1'b1;
        exp_cnt = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 3'd0;
        out_ready = 1'b1;
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
`endif
        exp_cnt   = '0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0 || beat_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b data=%h err=%b cnt=%h, required 0/00/0/0",
                     out_valid, out_data, out_err, beat_cnt);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        tick();
    endtask

    task automatic test_ops();
        logic [23:0] vec  [2] = '{24'h00F00F, 24'hF0CCAA};
        logic [7:0]  exp_a [6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        logic [7:0]  exp_b [6] = '{8'hFE, 8'h80, 8'h96, 8'h01, 8'h7F, 8'h69};
        logic [7:0]  expv;
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int op = 0; op < 6; op++) begin
                in_valid = 1'b1;
                in_data  = vec[v];
                in_op    = 3'(op);
                tick();
                exp_cnt = exp_cnt + 4'd1;
                expv = (v == 0) ? exp_a[op] : exp_b[op];
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== expv || out_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL op_result v%0d op%0d: valid=%b data=%h err=%b, required 1/%h/0",
                             v, op, out_valid, out_data, out_err, expv);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h69 || beat_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL op_drain: valid=%b data=%h cnt=%h, required 0/69/%h",
                     out_valid, out_data, beat_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_data   = 24'h000201;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_load_a: valid=%b data=%h ready=%b, required 1/03/0",
                     out_valid, out_data, in_ready);
        end
        in_data = 24'h002010;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || in_ready !== 1'b0 || beat_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL bp_hold_a: valid=%b data=%h ready=%b cnt=%h, required 1/03/0/%h",
                     out_valid, out_data, in_ready, beat_cnt, exp_cnt);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_comb: got %b, required 1", in_ready);
        end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h30 || beat_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL bp_pop_load_b: valid=%b data=%h cnt=%h, required 1/30/%h",
                     out_valid, out_data, beat_cnt, exp_cnt);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h30) begin
            n_fail++;
            $display("FAIL bp_pop_b: valid=%b data=%h, required 0/30", out_valid, out_data);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        in_op     = 3'd0;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            in_data  = {16'h0000, 8'(i * 3)};
            tick();
            exp_cnt = exp_cnt + 4'd1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i * 3) || beat_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL stream beat %0d: valid=%b data=%h cnt=%h, required 1/%h/%h",
                         i, out_valid, out_data, beat_cnt, 8'(i * 3), exp_cnt);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (beat_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL stream_final_cnt: got %0d, required 4", beat_cnt);
        end
        tick();
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'hFFFFFF;
        in_op     = 3'd6;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_6: valid=%b data=%h err=%b, required 1/00/1",
                     out_valid, out_data, out_err);
        end
        in_op = 3'd7;
        tick();
        n_checks++;
        if (out_data !== 8'h00 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_7: data=%h err=%b, required 00/1", out_data, out_err);
        end
        in_op = 3'd0;
        tick();
        n_checks++;
        if (out_data !== 8'hFF || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_recover: data=%h err=%b, required FF/0", out_data, out_err);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd2;
        in_data   = 24'h00005A;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL async_pre: valid=%b data=%h, required 1/5A", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || beat_cnt !== 4'h0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h cnt=%h err=%b, required 0/00/0/0",
                     out_valid, out_data, beat_cnt, out_err);
        end
        #2;
        rst_n     = 1'b1;
        exp_cnt   = '0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: valid=%b ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

`ifdef LOGIC_GATE_PIPE_ACCUM_EN
    task automatic test_accum();
        logic [23:0] dv [4] = '{24'h000001, 24'h000004, 24'h000080, 24'h000002};
        logic        cl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0]  ev [4] = '{8'h01, 8'h05, 8'h80, 8'h82};
        out_ready = 1'b1;
        acc_en    = 1'b1;
        in_op     = 3'd0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = dv[i];
            acc_clr  = cl[i];
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ev[i]) begin
                n_fail++;
                $display("FAIL accum beat %0d: valid=%b data=%h, required 1/%h",
                         i, out_valid, out_data, ev[i]);
            end
        end
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_back_pressure();
        test_streaming();
        test_reserved();
        test_async_reset();
`ifdef LOGIC_GATE_PIPE_ACCUM_EN
        test_accum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
